pll_reset_seq: RTL and testbench

- Consumer-side sequencer for the system PLL: drives the PLL's `rst` input and watches its `locked` output.
- Produces clean, staged, synchronous system resets once lock is stable.
- Runs on the 50 MHz PLL reference clock, so it keeps operating while the PLL output clocks are absent.
- Detects loss of lock, re-resets the PLL and reports retry and loss status.

---
 rtl/pll_reset_seq.sv | 180 ++++++++++++++++++
 tb/tb_pll_reset_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: consumer-side sequencer for the system PLL, clocked by refclk.
// It pulses the PLL reset, waits for a stable lock and then releases two
// staged system resets. If lock is lost, it resets the PLL again and records
// the retry and the loss.
//
// Optional feature: define PLL_TIMEOUT_EN to add a lock watchdog. If lock is
// not reached within TIMEOUT_CYCLES, the block pulses the PLL reset again.
//
// Ports:
//   refclk        in   reference clock; the only clock of this block
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL locked output, asynchronous to refclk
//   lock_lost_clr in   clears the lock_lost sticky flag
//   pll_rst       out  drives the PLL rst input
//   locked_sync   out  pll_locked after a 2-flop synchronizer
//   sys_rst_0     out  core reset, released first
//   sys_rst_1     out  peripheral reset, released STAGE_GAP cycles later
//   ready         out  high while running with a stable lock
//   retry_cnt     out  saturating count of PLL reset pulses after the first
//   lock_lost     out  sticky flag, set on a lock loss after release
module pll_reset_seq #(
   parameter int unsigned RST_CYCLES     = 16,
   parameter int unsigned LOCK_FILTER    = 1024,
   parameter int unsigned STAGE_GAP      = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       lock_lost_clr,
   output logic       pll_rst,
   output logic       locked_sync,
   output logic       sys_rst_0,
   output logic       sys_rst_1,
   output logic       ready,
   output logic [3:0] retry_cnt,
   output logic       lock_lost
);

   // One shared phase counter. It must hold RST_CYCLES-1, LOCK_FILTER-1 and STAGE_GAP.
   localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
   localparam int unsigned CNT_MAX = (MAX_A > STAGE_GAP + 1) ? MAX_A : STAGE_GAP + 1;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_PLLRST,
      S_WAIT,
      S_FILTER,
      S_REL,
      S_RUN
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          sync_q1;
   logic [3:0]    retry_next_c;

   // A value of zero is illegal for every parameter. This named block marks such a build.
   if (RST_CYCLES == 0 || LOCK_FILTER == 0 || STAGE_GAP == 0 || TIMEOUT_CYCLES == 0) begin : g_illegal_params
   end

   assign retry_next_c = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

`ifdef PLL_TIMEOUT_EN
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WW-1:0] wd;
   logic          wd_expired_c;

   assign wd_expired_c = (wd == WW'(TIMEOUT_CYCLES - 1));

   // Lock watchdog. It covers S_WAIT and S_FILTER and is not cleared when the filter falls back.
   always_ff @(posedge refclk) begin
      if (rst || state == S_PLLRST) begin
         wd <= '0;
      end else if (state == S_WAIT || state == S_FILTER) begin
         wd <= wd + WW'(1);
      end
   end
`endif

   // Synchronizer and sequencer. A clear and a set in the same cycle leave the flag set,
   // because the set assignment comes later in the block.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= S_PLLRST;
         cnt         <= '0;
         sync_q1     <= 1'b0;
         locked_sync <= 1'b0;
         pll_rst     <= 1'b1;
         sys_rst_0   <= 1'b1;
         sys_rst_1   <= 1'b1;
         ready       <= 1'b0;
         retry_cnt   <= 4'd0;
         lock_lost   <= 1'b0;
      end else begin
         sync_q1     <= pll_locked;
         locked_sync <= sync_q1;
         if (lock_lost_clr) begin
            lock_lost <= 1'b0;
         end

         case (state)
            S_PLLRST: begin
               if (cnt == CW'(RST_CYCLES - 1)) begin
                  state   <= S_WAIT;
                  pll_rst <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_WAIT: begin
`ifdef PLL_TIMEOUT_EN
               if (wd_expired_c) begin
                  state     <= S_PLLRST;
                  pll_rst   <= 1'b1;
                  cnt       <= '0;
                  retry_cnt <= retry_next_c;
               end else
`endif
               if (locked_sync) begin
                  state <= S_FILTER;
                  cnt   <= '0;
               end
            end

            S_FILTER: begin
`ifdef PLL_TIMEOUT_EN
               if (wd_expired_c) begin
                  state     <= S_PLLRST;
                  pll_rst   <= 1'b1;
                  cnt       <= '0;
                  retry_cnt <= retry_next_c;
               end else
`endif
               if (!locked_sync) begin
                  state <= S_WAIT;
               end else if (cnt == CW'(LOCK_FILTER - 1)) begin
                  state <= S_REL;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_REL, S_RUN: begin
               if (!locked_sync) begin
                  // Lock lost: put everything back into reset and pulse the PLL again.
                  state     <= S_PLLRST;
                  pll_rst   <= 1'b1;
                  cnt       <= '0;
                  sys_rst_0 <= 1'b1;
                  sys_rst_1 <= 1'b1;
                  ready     <= 1'b0;
                  lock_lost <= 1'b1;
                  retry_cnt <= retry_next_c;
               end else if (state == S_REL) begin
                  sys_rst_0 <= 1'b0;
                  if (cnt == CW'(STAGE_GAP)) begin
                     sys_rst_1 <= 1'b0;
                     ready     <= 1'b1;
                     state     <= S_RUN;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end

            default: begin
               state   <= S_PLLRST;
               pll_rst <= 1'b1;
               cnt     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq. Each cycle the stimulus is driven on the falling edge.
// A timer-based reference model predicts the outputs after the next rising edge and
// queues them. A monitor compares the DUT outputs against the queue.
module tb_pll_reset_seq;

   localparam int unsigned RST_CYCLES     = 4;
   localparam int unsigned LOCK_FILTER    = 8;
   localparam int unsigned STAGE_GAP      = 3;
   localparam int unsigned TIMEOUT_CYCLES = 50;
`ifdef PLL_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   typedef struct packed {
      logic       pll_rst;
      logic       locked_sync;
      logic       sys_rst_0;
      logic       sys_rst_1;
      logic       ready;
      logic [3:0] retry_cnt;
      logic       lock_lost;
   } obs_t;

   typedef struct {
      obs_t  o;
      string tag;
      int    cyc;
   } exp_t;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       lock_lost_clr = 1'b0;
   logic       pll_rst;
   logic       locked_sync;
   logic       sys_rst_0;
   logic       sys_rst_1;
   logic       ready;
   logic [3:0] retry_cnt;
   logic       lock_lost;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];

   pll_reset_seq #(
      .RST_CYCLES    (RST_CYCLES),
      .LOCK_FILTER   (LOCK_FILTER),
      .STAGE_GAP     (STAGE_GAP),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .lock_lost_clr(lock_lost_clr),
      .pll_rst      (pll_rst),
      .locked_sync  (locked_sync),
      .sys_rst_0    (sys_rst_0),
      .sys_rst_1    (sys_rst_1),
      .ready        (ready),
      .retry_cnt    (retry_cnt),
      .lock_lost    (lock_lost)
   );

   always #5 refclk = ~refclk;

   // Reference model, expressed as timers:
   //   m_pulse  - PLL reset cycles still to go (greater than 0 while pulsing)
   //   m_rel    - -1 while acquiring lock, otherwise the count of good cycles since release started
   //   m_streak - consecutive synchronized-lock samples seen while acquiring
   //   m_acq    - cycles spent acquiring since the last pulse ended (watchdog)
   //   m_sync   - the two-sample delay line that models the synchronizer
   int   m_pulse = 0;
   int   m_rel = -1;
   int   m_streak = 0;
   int   m_acq = 0;
   logic m_sync[2] = '{1'b0, 1'b0};
   obs_t m_out;

   function automatic void model_restart(input bit was_loss);
      m_pulse           = RST_CYCLES;
      m_rel             = -1;
      m_out.pll_rst     = 1'b1;
      m_out.sys_rst_0   = 1'b1;
      m_out.sys_rst_1   = 1'b1;
      m_out.ready       = 1'b0;
      m_out.retry_cnt   = (m_out.retry_cnt == 4'd15) ? 4'd15 : m_out.retry_cnt + 4'd1;
      if (was_loss) m_out.lock_lost = 1'b1;
   endfunction

   function automatic void model_step(input logic r, input logic lk, input logic clr);
      logic ls;
      if (r) begin
         m_sync   = '{1'b0, 1'b0};
         m_pulse  = RST_CYCLES;
         m_rel    = -1;
         m_streak = 0;
         m_acq    = 0;
         m_out    = '{pll_rst: 1'b1, locked_sync: 1'b0, sys_rst_0: 1'b1, sys_rst_1: 1'b1,
                      ready: 1'b0, retry_cnt: 4'd0, lock_lost: 1'b0};
         return;
      end
      ls                = m_sync[1];
      m_sync[1]         = m_sync[0];
      m_sync[0]         = lk;
      m_out.locked_sync = m_sync[1];
      if (clr) m_out.lock_lost = 1'b0;
      if (m_pulse > 0) begin
         m_pulse--;
         if (m_pulse == 0) begin
            m_out.pll_rst = 1'b0;
            m_streak      = 0;
            m_acq         = 0;
         end
      end else if (m_rel < 0) begin
         if (TIMEOUT_EN && m_acq == int'(TIMEOUT_CYCLES) - 1) begin
            model_restart(1'b0);
         end else begin
            m_acq++;
            m_streak = ls ? m_streak + 1 : 0;
            // Release starts once lock has been seen on LOCK_FILTER+1 consecutive samples.
            if (m_streak == int'(LOCK_FILTER) + 1) m_rel = 0;
         end
      end else if (!ls) begin
         model_restart(1'b1);
      end else begin
         m_rel++;
         if (m_rel == 1) m_out.sys_rst_0 = 1'b0;
         if (m_rel == int'(STAGE_GAP) + 1) begin
            m_out.sys_rst_1 = 1'b0;
            m_out.ready     = 1'b1;
         end
      end
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("pll_rst=%b locked_sync=%b sys_rst_0=%b sys_rst_1=%b ready=%b retry_cnt=%0d lock_lost=%b",
                       o.pll_rst, o.locked_sync, o.sys_rst_0, o.sys_rst_1, o.ready, o.retry_cnt, o.lock_lost);
   endfunction

   task automatic drive(input logic r, input logic lk, input logic clr, input string tag);
      exp_t e;
      @(negedge refclk);
      rst           = r;
      pll_locked    = lk;
      lock_lost_clr = clr;
      model_step(r, lk, clr);
      cyc++;
      e.o   = m_out;
      e.tag = tag;
      e.cyc = cyc;
      exp_q.push_back(e);
   endtask

   // Monitor: compare the outputs after every rising edge that has a prediction queued.
   initial begin
      exp_t e;
      obs_t act;
      forever begin
         @(posedge refclk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = '{pll_rst, locked_sync, sys_rst_0, sys_rst_1, ready, retry_cnt, lock_lost};
            checks++;
            if (act !== e.o) begin
               errors++;
               $display("FAIL %s cycle %0d: got %s expected %s", e.tag, e.cyc, fmt(act), fmt(e.o));
            end
         end
      end
   end

   initial begin
      logic lk;
      int   run;

      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, "reset");

      // Normal bring-up, with lock appearing at cycle 10.
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, "bringup");
      for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b0, "bringup");

      // One-cycle lock loss while running, then clear the sticky flag.
      drive(1'b0, 1'b0, 1'b0, "lockloss");
      for (int i = 0; i < 35; i++) drive(1'b0, 1'b1, 1'b0, "lockloss");
      drive(1'b0, 1'b1, 1'b1, "lostclr");
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, "lostclr");

      // Glitchy lock during acquisition: the filter restarts and there is no extra PLL reset.
      drive(1'b1, 1'b0, 1'b0, "glitch");
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, "glitch");
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, "glitch");
      drive(1'b0, 1'b0, 1'b0, "glitch");
      for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b0, "glitch");

      // 17 forced lock losses: retry_cnt must saturate at 15.
      for (int k = 0; k < 17; k++) begin
         drive(1'b0, 1'b0, 1'b0, "saturate");
         for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b0, "saturate");
      end

      // Mid-operation reset at a sweep of offsets, covering the filter and the staged release.
      for (int off = 0; off < 21; off++) begin
         drive(1'b1, 1'b1, 1'b0, "midrst");
         for (int i = 0; i < 4 + off; i++) drive(1'b0, 1'b1, 1'b0, "midrst");
      end
      drive(1'b1, 1'b1, 1'b0, "midrst");

      // Lock never arrives: one pulse, or periodic pulses when the watchdog is enabled.
      for (int i = 0; i < 170; i++) drive(1'b0, 1'b0, 1'b0, "nolock");

      // Random lock runs, lock_lost_clr pulses and occasional resets.
      lk  = 1'b0;
      run = 0;
      for (int i = 0; i < 1500; i++) begin
         if (run == 0) begin
            lk  = ~lk;
            run = lk ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 4));
         end
         run--;
         drive(logic'($urandom_range(0, 299) == 0), lk, logic'($urandom_range(0, 7) == 0), "random");
      end

      repeat (3) @(posedge refclk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
